mult_ctrl_unit: RTL and testbench

- Sequencing FSM for the 8-bit signed shift-add multiplier datapath (A accumulator, X sign bit, B multiplier register, 9-bit adder).
- Decodes the ClearA_LoadB and Run user controls into per-cycle strobes: clear/load, add, subtract, shift.
- Issues W add/shift pairs and subtracts on the final iteration (two's-complement sign weight).
- Sits between the debounced/synchronised switch logic and the multiplier register file.

---
 rtl/mult_ctrl_unit_if.sv | 30 +++
 rtl/mult_ctrl_unit.sv | 112 +++++++++++
 tb/tb_mult_ctrl_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_unit_if.sv
// Control/strobe bundle between the multiplier sequencer and its register file.
// Run is a level request: a multiply starts when Run is seen high in IDLE, Done holds until Run drops.
interface mult_ctrl_unit_if #(
    parameter int WIDTH = 8
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic          Run;
    logic          ClearA_LoadB;
    logic          M;
    logic          Clr_Ld;
    logic          Clr_AX;
    logic          Add;
    logic          Sub;
    logic          Shift;
    logic          Busy;
    logic          Done;
    logic [IW-1:0] Iter;
    logic [2:0]    state_dbg;

    modport master (
        output Run, ClearA_LoadB, M,
        input  Clr_Ld, Clr_AX, Add, Sub, Shift, Busy, Done, Iter, state_dbg
    );

    modport slave (
        input  Run, ClearA_LoadB, M,
        output Clr_Ld, Clr_AX, Add, Sub, Shift, Busy, Done, Iter, state_dbg
    );
endinterface

// File: rtl/mult_ctrl_unit.sv
// Sequencer for the signed shift-add multiplier: WIDTH add/shift pairs, subtract on the sign bit.
// Optional MULT_CTRL_SKIP_ZERO_EN: a zero multiplier bit is handled with a single shift cycle.
module mult_ctrl_unit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    mult_ctrl_unit_if.slave  bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLRA  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] iter;
    logic [IW-1:0] iter_nxt;
    logic          clr_ld;
    logic          clr_ax;
    logic          add;
    logic          sub;
    logic          shift;
    logic          busy;
    logic          done;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            iter  <= iter_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        iter_nxt  = iter;
        clr_ld    = 1'b0;
        clr_ax    = 1'b0;
        add       = 1'b0;
        sub       = 1'b0;
        shift     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                // Run wins over a simultaneous load request.
                if (bus.Run) state_nxt = S_CLRA;
                else         clr_ld    = bus.ClearA_LoadB;
            end
            S_CLRA: begin
                clr_ax    = 1'b1;
                busy      = 1'b1;
                iter_nxt  = '0;
                state_nxt = S_ADD;
            end
            S_ADD: begin
                busy = 1'b1;
`ifdef MULT_CTRL_SKIP_ZERO_EN
                if (!bus.M) begin
                    shift = 1'b1;
                    if (iter == LAST) state_nxt = S_HALT;
                    else              iter_nxt  = iter + 1'b1;
                end else begin
                    add       = (iter != LAST);
                    sub       = (iter == LAST);
                    state_nxt = S_SHIFT;
                end
`else
                // The top bit carries negative weight in two's complement.
                add       = bus.M && (iter != LAST);
                sub       = bus.M && (iter == LAST);
                state_nxt = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
                if (iter == LAST) begin
                    state_nxt = S_HALT;
                end else begin
                    iter_nxt  = iter + 1'b1;
                    state_nxt = S_ADD;
                end
            end
            S_HALT: begin
                done = 1'b1;
                if (!bus.Run) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Clr_Ld is the only output fed straight from an input, so it alone needs reset gating.
    assign bus.Clr_Ld    = clr_ld & Reset_n;
    assign bus.Clr_AX    = clr_ax;
    assign bus.Add       = add;
    assign bus.Sub       = sub;
    assign bus.Shift     = shift;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.Iter      = iter;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_mult_ctrl_unit.sv
// Bench for mult_ctrl_unit: a register-file model feeds M back, a schedule model checks every cycle.
module tb_mult_ctrl_unit;
    localparam int W  = 8;
    localparam int IW = $clog2(W);
    localparam int VW = 7 + IW;
`ifdef MULT_CTRL_SKIP_ZERO_EN
    localparam int BUSY07 = 12;
`else
    localparam int BUSY07 = 17;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mult_ctrl_unit_if #(.WIDTH(W)) bus ();

    mult_ctrl_unit #(.WIDTH(W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Register file: A, X, B and the S operand (din), driven by the strobes.
    logic [7:0] din  = '0;
    logic [7:0] dp_a = '0;
    logic [7:0] dp_b = '0;
    logic       dp_x = 1'b0;

    always @(posedge clk) begin
        if (bus.Clr_Ld) begin
            dp_a <= '0;
            dp_x <= 1'b0;
            dp_b <= din;
        end else if (bus.Clr_AX) begin
            dp_a <= '0;
            dp_x <= 1'b0;
        end else if (bus.Add) begin
            {dp_x, dp_a} <= {dp_a[7], dp_a} + {din[7], din};
        end else if (bus.Sub) begin
            {dp_x, dp_a} <= {dp_a[7], dp_a} - {din[7], din};
        end else if (bus.Shift) begin
            {dp_x, dp_a, dp_b} <= {dp_x, dp_x, dp_a, dp_b[7:1]};
        end
    end

    assign bus.M = dp_b[0];

    function automatic logic [VW-1:0] mk(input logic cl, input logic ca, input logic ad,
                                         input logic sb, input logic sh, input logic bz,
                                         input logic dn, input logic [IW-1:0] it);
        return {cl, ca, ad, sb, sh, bz, dn, it};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.Clr_Ld, bus.Clr_AX, bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done, bus.Iter};
    endfunction

    // Schedule model: mode 0 idle, 1 running through exp_q, 2 result held.
    logic [VW-1:0] exp_q[$];
    int            mode   = 0;
    logic [IW-1:0] m_iter = '0;

    task automatic start_model(input logic [7:0] b);
        exp_q.push_back(mk(0, 1, 0, 0, 0, 1, 0, m_iter));
        for (int i = 0; i < W; i++) begin
`ifdef MULT_CTRL_SKIP_ZERO_EN
            if (!b[i]) begin
                exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, IW'(i)));
            end else begin
                exp_q.push_back(mk(0, 0, i < W - 1, i == W - 1, 0, 1, 0, IW'(i)));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, IW'(i)));
            end
`else
            exp_q.push_back(mk(0, 0, b[i] && (i < W - 1), b[i] && (i == W - 1), 0, 1, 0, IW'(i)));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, IW'(i)));
`endif
        end
    endtask

    function automatic logic [VW-1:0] expected_now();
        if (!rst_n)    return '0;
        if (mode == 1) return exp_q[0];
        if (mode == 2) return mk(0, 0, 0, 0, 0, 0, 1, IW'(W - 1));
        return mk(bus.ClearA_LoadB && !bus.Run, 0, 0, 0, 0, 0, 0, m_iter);
    endfunction

    int cnt_clrld, cnt_clrax, cnt_add, cnt_sub, cnt_shift, cnt_busy;

    task automatic clear_counts();
        cnt_clrld = 0; cnt_clrax = 0; cnt_add = 0;
        cnt_sub   = 0; cnt_shift = 0; cnt_busy = 0;
    endtask

    // Compare at the falling edge, advance the model at the rising edge.
    initial begin
        logic [VW-1:0] exp_v;
        logic [VW-1:0] got_v;
        forever begin
            @(negedge clk);
            exp_v = expected_now();
            got_v = dut_vec();
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle_check t=%0t got=%b expected=%b", $time, got_v, exp_v);
            end
            cnt_clrld += int'(bus.Clr_Ld);
            cnt_clrax += int'(bus.Clr_AX);
            cnt_add   += int'(bus.Add);
            cnt_sub   += int'(bus.Sub);
            cnt_shift += int'(bus.Shift);
            cnt_busy  += int'(bus.Busy);
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                mode   = 0;
                m_iter = '0;
            end else if (mode == 0) begin
                if (bus.Run) begin
                    start_model(dp_b);
                    mode = 1;
                end
            end else if (mode == 1) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    mode   = 2;
                    m_iter = IW'(W - 1);
                end
            end else if (!bus.Run) begin
                mode = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.Done && lat < 100) begin
            step(1);
            lat++;
        end
        n_cmp++;
        if (!bus.Done) begin
            n_err++;
            $display("FAIL done_timeout got=0 expected=1 after %0d cycles", lat);
        end
    endtask

    task automatic do_mult(input logic [7:0] b, input logic [7:0] s, output int lat);
        int p;
        din = b;
        bus.ClearA_LoadB = 1'b1;
        step(1);
        bus.ClearA_LoadB = 1'b0;
        din = s;
        clear_counts();
        bus.Run = 1'b1;
        wait_done(lat);
        p = $signed(s) * $signed(b);
        check("product", {16'h0, dp_a, dp_b}, {16'h0, p[15:0]});
    endtask

    initial begin
        int         lat;
        logic [7:0] b0;
        int         p;
        bus.Run = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        clear_counts();
        step(3);
        check("reset_outputs", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1;
        step(2);

        // Load request alone for three cycles.
        clear_counts();
        din = 8'h07;
        bus.ClearA_LoadB = 1'b1;
        step(3);
        bus.ClearA_LoadB = 1'b0;
        step(2);
        check("clrld_cycles", 32'(cnt_clrld), 32'd3);
        check("clrld_no_other", 32'(cnt_clrax + cnt_add + cnt_sub + cnt_shift + cnt_busy), 32'd0);

        // B=0x07, S=0x05.
        do_mult(8'h07, 8'h05, lat);
        check("b07_product", {16'h0, dp_a, dp_b}, 32'h0023);
        check("b07_adds", 32'(cnt_add), 32'd3);
        check("b07_subs", 32'(cnt_sub), 32'd0);
        check("b07_shifts", 32'(cnt_shift), 32'd8);
        check("b07_clrax", 32'(cnt_clrax), 32'd1);
        check("b07_busy", 32'(cnt_busy), 32'(BUSY07));
        check("b07_latency", 32'(lat), 32'(BUSY07 + 1));

        // Run held long after Done: no re-trigger.
        clear_counts();
        step(50);
        check("hold_no_rerun", 32'(cnt_busy), 32'd0);
        check("hold_done", 32'(bus.Done), 32'd1);
        bus.Run = 1'b0;
        step(2);
        check("done_drops", 32'(bus.Done), 32'd0);

        // B=0xFE, S=0x07: -14.
        do_mult(8'hFE, 8'h07, lat);
        check("bfe_product", {16'h0, dp_a, dp_b}, 32'hFFF2);
        check("bfe_adds", 32'(cnt_add), 32'd6);
        check("bfe_subs", 32'(cnt_sub), 32'd1);
        check("bfe_shifts", 32'(cnt_shift), 32'd8);
        bus.Run = 1'b0;
        step(2);

        // Run and load together: Run wins, load ignored throughout.
        clear_counts();
        b0  = dp_b;
        din = 8'h3C;
        bus.ClearA_LoadB = 1'b1;
        bus.Run = 1'b1;
        step(1);
        check("both_clrax", 32'(bus.Clr_AX), 32'd1);
        check("both_clrld", 32'(bus.Clr_Ld), 32'd0);
        wait_done(lat);
        p = $signed(din) * $signed(b0);
        check("both_product", {16'h0, dp_a, dp_b}, {16'h0, p[15:0]});
        check("both_no_clrld", 32'(cnt_clrld), 32'd0);
        bus.Run = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        step(2);

        // Reset in SHIFT at Iter=3, then a fresh multiply.
        din = 8'hA5;
        bus.ClearA_LoadB = 1'b1;
        step(1);
        bus.ClearA_LoadB = 1'b0;
        bus.Run = 1'b1;
        lat = 0;
        while (!(bus.Shift && bus.Iter == IW'(3)) && lat < 40) begin
            step(1);
            lat++;
        end
        check("reach_shift3", 32'(bus.Shift && bus.Iter == IW'(3)), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_shift", 32'(dut_vec()), 32'h0);
        step(2);
        check("reset_held", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1;
        step(1);
        check("restart_clrax", 32'(bus.Clr_AX), 32'd1);
        wait_done(lat);
        bus.Run = 1'b0;
        step(2);

        // Random operands and idle/halt timing.
        for (int k = 0; k < 24; k++) begin
            do_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), lat);
            repeat ($urandom_range(0, 6)) begin
                bus.ClearA_LoadB = 1'($urandom_range(0, 1));
                step(1);
            end
            bus.Run = 1'b0;
            repeat ($urandom_range(1, 4)) begin
                bus.ClearA_LoadB = 1'($urandom_range(0, 1));
                step(1);
            end
            bus.ClearA_LoadB = 1'b0;
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
